// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin Wishbone arbiter with cycle-long ownership and bus watchdog
module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_n;
  logic last, last_n;
  logic [15:0] wdog;
  logic wdog_hit, g0, g1;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign wdog_hit = (TIMEOUT != 0) && (wdog == 16'(TIMEOUT));
  // next grant: round-robin from idle, hold while the owner keeps CYC, hand over directly on release
  always_comb begin
    state_n = state;
    last_n  = last;
    if (!g0 && !g1)
      state_n = (m0_cyc_i && (!m1_cyc_i || last)) ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
    else if (g0 && !m0_cyc_i) begin
      state_n = m1_cyc_i ? GNT1 : IDLE;
      last_n  = 1'b0;
    end else if (g1 && !m1_cyc_i) begin
      state_n = m0_cyc_i ? GNT0 : IDLE;
      last_n  = 1'b1;
    end
  end
  assign s_cyc_o  = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign s_stb_o  = (g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0) & ~wdog_hit;
  assign s_we_o   = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
  assign s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
  assign s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
  assign s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
  assign m0_ack_o = g0 & s_ack_i;
  assign m1_ack_o = g1 & s_ack_i;
  assign m0_err_o = g0 & (s_err_i | wdog_hit);
  assign m1_err_o = g1 & (s_err_i | wdog_hit);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  // grant state, round-robin history and saturating stall counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      wdog  <= (state_n != state || !s_stb_o || s_ack_i || s_err_i) ? '0 : wdog + {15'b0, wdog != 16'hffff};
    end
  end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed arbitration/watchdog scenarios plus randomized two-master scoreboard run
module tb_wb_arbiter2;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] m_cyc = '0, m_stb = '0, m_we = '0;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0] m_sel [2];
  logic [31:0] s_dat_i = '0;
  logic s_ack_i = 1'b0, s_err_i = 1'b0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0] s_sel_o;
  logic m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] z_dat0, z_dat1, z_adr, z_sdat;
  logic [3:0] z_sel;
  logic z_ack0, z_ack1, z_err0, z_err1, z_we, z_cyc, z_stb;

  wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(m0_dat_o), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(m1_dat_o), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(0)) dut_nowd (
    .clk_i(clk), .rst_i(rst_i),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(z_dat0), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_ack_o(z_ack0), .m0_err_o(z_err0),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(z_dat1), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_ack_o(z_ack1), .m1_err_o(z_err1),
    .s_adr_o(z_adr), .s_dat_o(z_sdat), .s_sel_o(z_sel), .s_we_o(z_we),
    .s_cyc_o(z_cyc), .s_stb_o(z_stb), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  typedef struct packed {logic rd; logic [31:0] d;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] smem [128];
  logic [31:0] rmem [128];
  logic [1:0] got_ack = '0;
  bit mon_en = 1'b0;
  int checks = 0, errors = 0;
  int left [2];
  int wait_c [2];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_seq();
    step();
    rst_i = 1'b1; m_cyc = '0; m_stb = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    step();
    rst_i = 1'b0;
  endtask

  task automatic new_beat(input int x);
    int idx;
    exp_t e;
    idx = x * 64 + int'($urandom_range(0, 63));
    m_we[x] = 1'($urandom_range(0, 1));
    m_adr[x] = 32'(idx);
    m_dat[x] = $urandom;
    m_sel[x] = 4'($urandom);
    e.rd = !m_we[x];
    e.d = rmem[idx];
    if (m_we[x]) rmem[idx] = m_dat[x];
    if (x == 0) q0.push_back(e); else q1.push_back(e);
    wait_c[x] = 0;
  endtask

  // monitor: slave memory, routing checks and scoreboard pops on every master-sampled ACK
  initial forever begin
    exp_t e;
    int o;
    @(negedge clk);
    got_ack = {m1_ack_o & m_stb[1], m0_ack_o & m_stb[0]};
    if (mon_en) begin
      chk("ack_excl", 32'(m0_ack_o & m1_ack_o), 0);
      chk("err0", 32'(m0_err_o), 0);
      chk("err1", 32'(m1_err_o), 0);
      if (s_cyc_o && s_stb_o && s_ack_i) begin
        o = int'(s_adr_o[6]);
        chk("ack_route", {30'b0, m1_ack_o, m0_ack_o}, o == 1 ? 32'd2 : 32'd1);
        chk("s_adr", s_adr_o, m_adr[o]);
        chk("s_req", 32'(m_cyc[o] & m_stb[o]), 1);
        chk("s_we", 32'(s_we_o), 32'(m_we[o]));
        chk("s_sel", 32'(s_sel_o), 32'(m_sel[o]));
        if (s_we_o) begin
          chk("s_dat", s_dat_o, m_dat[o]);
          smem[s_adr_o[6:0]] = s_dat_o;
        end
      end
      for (int x = 0; x < 2; x++) if (got_ack[x]) begin
        if (x == 0 && q0.size() == 0) chk("q0_under", 1, 0);
        else if (x == 1 && q1.size() == 0) chk("q1_under", 1, 0);
        else begin
          if (x == 0) e = q0.pop_front(); else e = q1.pop_front();
          if (e.rd) chk(x == 0 ? "rdata0" : "rdata1", x == 0 ? m0_dat_o : m1_dat_o, e.d);
        end
      end
    end
  end

  initial begin
    int n, a0, fall, first1, swait, slat;
    for (int i = 0; i < 128; i++) begin
      smem[i] = $urandom;
      rmem[i] = smem[i];
    end
    for (int x = 0; x < 2; x++) begin
      m_adr[x] = '0; m_dat[x] = '0; m_sel[x] = '0; left[x] = 0; wait_c[x] = 0;
    end

    step();
    rst_i = 1'b1; m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b11; s_ack_i = 1'b1;
    m_adr[0] = 32'h100; m_adr[1] = 32'h200; m_dat[0] = 32'h1111; m_dat[1] = 32'h2222;
    m_sel[0] = 4'hf; m_sel[1] = 4'hf;
    step();
    @(negedge clk);
    chk("rst_ctl", {25'b0, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    chk("rst_adr", s_adr_o, 0);
    chk("rst_dat", s_dat_o, 0);
    chk("rst_sel", 32'(s_sel_o), 0);
    step();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rel_idle", 32'(s_cyc_o), 0);
    step();
    @(negedge clk);
    chk("first_grant", s_adr_o, 32'h100);
    chk("first_ack0", 32'(m0_ack_o), 1);
    chk("first_ack1", 32'(m1_ack_o), 0);

    rst_seq();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h10;
    @(negedge clk);
    chk("t2_stb_req", 32'(s_stb_o), 0);
    step();
    @(negedge clk);
    chk("t2_stb_gnt", 32'(s_stb_o), 1);
    chk("t2_adr", s_adr_o, 32'h10);
    chk("t2_early_ack", 32'(m1_ack_o), 0);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_ack1", 32'(m1_ack_o), 1);
    chk("t2_dat1", m1_dat_o, 32'hDEADBEEF);
    chk("t2_ack0", 32'(m0_ack_o), 0);

    rst_seq();
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) step();
      m_cyc = ~got_ack; m_stb = ~got_ack;
      #1;
      s_ack_i = s_stb_o;
      @(negedge clk);
      if (m0_ack_o || m1_ack_o) begin
        chk("t3_order", {30'b0, m1_ack_o, m0_ack_o}, n % 2 == 1 ? 32'd2 : 32'd1);
        n++;
      end
    end
    chk("t3_count", n, 6);

    rst_seq();
    a0 = 0; fall = -1; first1 = -1;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) step();
      m_cyc[0] = a0 < 4;
      if (a0 >= 4 && fall < 0) fall = c;
      m_cyc[1] = first1 < 0;
      m_stb = m_cyc;
      #1;
      s_ack_i = s_stb_o;
      @(negedge clk);
      if (m0_ack_o) a0++;
      if (m1_ack_o && first1 < 0) first1 = c;
    end
    chk("t4_beats", a0, 4);
    chk("t4_fall", fall, 5);
    chk("t4_m1_first", first1, fall + 1);

    rst_seq();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c != 0) step();
      @(negedge clk);
      chk("t5_err", 32'(m0_err_o), 32'(c == 9));
      chk("t5_stb", 32'(s_stb_o), 32'(c >= 1 && c != 9));
      chk("t5_off_err", 32'(z_err0), 0);
      chk("t5_off_stb", 32'(z_stb), 32'(c >= 1));
    end

    rst_seq();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    @(negedge clk);
    chk("t6_pre", 32'(s_cyc_o), 1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; s_ack_i = 1'b1;
    @(negedge clk);
    chk("t6_cyc", 32'(s_cyc_o), 0);
    chk("t6_ackerr", {30'b0, m1_ack_o, m1_err_o}, 0);

    rst_seq();
    m_we = '0;
    swait = 0; slat = 0;
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) step();
      for (int x = 0; x < 2; x++) begin
        if (got_ack[x]) begin
          left[x]--;
          if (left[x] == 0) begin
            m_cyc[x] = 1'b0; m_stb[x] = 1'b0;
          end else new_beat(x);
        end else if (m_cyc[x]) begin
          wait_c[x]++;
          if (wait_c[x] > 40) begin
            chk(x == 0 ? "starve0" : "starve1", wait_c[x], 40);
            wait_c[x] = 0;
          end
        end else if (c < 2800 && $urandom_range(0, 2) == 0) begin
          left[x] = int'($urandom_range(1, 4));
          m_cyc[x] = 1'b1; m_stb[x] = 1'b1;
          new_beat(x);
        end
      end
      #1;
      s_ack_i = 1'b0;
      if (s_cyc_o && s_stb_o) begin
        s_ack_i = swait >= slat;
        if (s_ack_i) begin
          swait = 0;
          slat = int'($urandom_range(0, 3));
        end else swait++;
      end
      s_dat_i = (s_ack_i && !s_we_o) ? smem[s_adr_o[6:0]] : $urandom;
    end
    @(negedge clk);
    mon_en = 1'b0;
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    chk("idle_end", 32'(m_cyc), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
